// File: rtl/serial_subtractor.sv
// Bit-serial a - b sequencer driving an external 1-bit full-subtractor cell.
// The operands go to the cell LSB-first, and the cell's difference bits are collected into diff.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | presenting one bit per clock to the cell, WIDTH bits in total
// DONE  | done pulse; diff/borrow valid
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_bin,
  input  logic             cell_d,
  input  logic             cell_bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             in_shift;
  logic [WIDTH-1:0] sr_next;

  assign in_shift = (state == SHIFT);
  assign cell_a   = in_shift & ra[0];
  assign cell_b   = in_shift & rb[0];
  assign cell_bin = in_shift & br;
  assign sr_next  = {cell_d, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      sr     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          sr  <= sr_next;
          br  <= cell_bout;
          cnt <= cnt + 1'b1;
          // The last bit's cell outputs go straight into diff/borrow, so they are already valid in the done cycle.
          if (cnt == LAST) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= sr_next;
            borrow <= cell_bout;
            state  <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          // The edge that ends the done cycle can take the next request, which keeps back-to-back throughput at WIDTH+1 cycles.
          if (start) begin
            ra    <= a;
            rb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
